// File: rtl/dcache_responder.sv
// Direct-mapped, write-back, write-allocate data cache between the CPU memory
// stage and a 128-bit block memory. Hits are served combinationally with no
// stall; misses optionally write back a dirty victim, then refill the line.
// Ports:
//   CLK, RESET (async, active-low)
//   CPU side : MEMREAD, MEMWRITE, ADDRESS, WRITEDATA -> READDATA, BUSYWAIT, HIT
//   Mem side : MEM_READ, MEM_WRITE, MEM_ADDRESS, MEM_WRITEDATA -> MEM_READDATA, MEM_BUSYWAIT
module dcache_responder #(
    parameter int unsigned SETS = 8
) (
    input  logic         CLK,
    input  logic         RESET,
    input  logic         MEMREAD,
    input  logic         MEMWRITE,
    input  logic [31:0]  ADDRESS,
    input  logic [31:0]  WRITEDATA,
    output logic [31:0]  READDATA,
    output logic         BUSYWAIT,
    output logic         HIT,
    output logic         MEM_READ,
    output logic         MEM_WRITE,
    output logic [27:0]  MEM_ADDRESS,
    output logic [127:0] MEM_WRITEDATA,
    input  logic [127:0] MEM_READDATA,
    input  logic         MEM_BUSYWAIT
);

    localparam int unsigned IW = $clog2(SETS);
    localparam int unsigned TW = 28 - IW;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITEBACK = 2'd1,
        ALLOCATE  = 2'd2,
        UPDATE    = 2'd3
    } state_e;

    state_e state_q, state_d;

    logic           valid_q [SETS];
    logic           dirty_q [SETS];
    logic [TW-1:0]  tag_q   [SETS];
    logic [127:0]   data_q  [SETS];

    logic [27:0]    miss_addr_q;
    logic [127:0]   fill_q;

    logic [IW-1:0]  idx_c;
    logic [TW-1:0]  tag_in_c;
    logic [6:0]     word_sel_c;
    logic [IW-1:0]  miss_idx_c;
    logic           req_c;
    logic           hit_c;
    logic           busy_c;
    logic           served_c;
    logic           wr_hit_c;
    logic           miss_load_c;

    // Address decode of the live CPU request
    assign idx_c      = ADDRESS[IW+3:4];
    assign tag_in_c   = ADDRESS[31:IW+4];
    assign word_sel_c = {ADDRESS[3:2], 5'b0};
    assign miss_idx_c = miss_addr_q[IW-1:0];
    assign req_c      = MEMREAD | MEMWRITE;
    assign hit_c      = valid_q[idx_c] && (tag_q[idx_c] == tag_in_c);

    // Selected word of the addressed line; only meaningful on a read hit
    assign READDATA = data_q[idx_c][word_sel_c +: 32];

    // Stall and hit are forced low while reset is held, even with a request up
    assign BUSYWAIT = busy_c & RESET;
    assign HIT      = served_c & RESET;

    // State register
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and memory-side outputs
    always_comb begin
        state_d       = state_q;
        busy_c        = 1'b0;
        served_c      = 1'b0;
        wr_hit_c      = 1'b0;
        miss_load_c   = 1'b0;
        MEM_READ      = 1'b0;
        MEM_WRITE     = 1'b0;
        MEM_ADDRESS   = 28'h0;
        MEM_WRITEDATA = 128'h0;
        case (state_q)
            IDLE: begin
                if (req_c) begin
                    if (hit_c) begin
                        served_c = 1'b1;
                        wr_hit_c = MEMWRITE;
                    end else begin
                        busy_c      = 1'b1;
                        miss_load_c = 1'b1;
                        state_d     = (valid_q[idx_c] && dirty_q[idx_c]) ? WRITEBACK : ALLOCATE;
                    end
                end
            end
            WRITEBACK: begin
                busy_c        = 1'b1;
                MEM_WRITE     = 1'b1;
                MEM_ADDRESS   = {tag_q[miss_idx_c], miss_idx_c};
                MEM_WRITEDATA = data_q[miss_idx_c];
                if (!MEM_BUSYWAIT) state_d = ALLOCATE;
            end
            ALLOCATE: begin
                busy_c      = 1'b1;
                MEM_READ    = 1'b1;
                MEM_ADDRESS = miss_addr_q;
                if (!MEM_BUSYWAIT) state_d = UPDATE;
            end
            UPDATE: begin
                busy_c  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Miss address is latched so the memory address stays stable for the whole miss
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            miss_addr_q <= 28'h0;
            fill_q      <= 128'h0;
        end else begin
            if (miss_load_c) miss_addr_q <= ADDRESS[31:4];
            if (state_q == ALLOCATE && !MEM_BUSYWAIT) fill_q <= MEM_READDATA;
        end
    end

    // Line storage: word writes on hits, whole-line fill in UPDATE
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            for (int i = 0; i < SETS; i++) begin
                valid_q[i] <= 1'b0;
                dirty_q[i] <= 1'b0;
                tag_q[i]   <= '0;
                data_q[i]  <= 128'h0;
            end
        end else begin
            if (wr_hit_c) begin
                data_q[idx_c][word_sel_c +: 32] <= WRITEDATA;
                dirty_q[idx_c]                  <= 1'b1;
            end
            if (state_q == UPDATE) begin
                data_q[miss_idx_c]  <= fill_q;
                tag_q[miss_idx_c]   <= miss_addr_q[27:IW];
                valid_q[miss_idx_c] <= 1'b1;
                dirty_q[miss_idx_c] <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_dcache_responder.sv
module tb_dcache_responder;

    localparam int unsigned LAT = 5;

    logic         CLK;
    logic         RESET;
    logic         MEMREAD;
    logic         MEMWRITE;
    logic [31:0]  ADDRESS;
    logic [31:0]  WRITEDATA;
    logic [31:0]  READDATA;
    logic         BUSYWAIT;
    logic         HIT;
    logic         MEM_READ;
    logic         MEM_WRITE;
    logic [27:0]  MEM_ADDRESS;
    logic [127:0] MEM_WRITEDATA;
    logic [127:0] MEM_READDATA;
    logic         MEM_BUSYWAIT;

    dcache_responder #(.SETS(8)) dut (
        .CLK          (CLK),
        .RESET        (RESET),
        .MEMREAD      (MEMREAD),
        .MEMWRITE     (MEMWRITE),
        .ADDRESS      (ADDRESS),
        .WRITEDATA    (WRITEDATA),
        .READDATA     (READDATA),
        .BUSYWAIT     (BUSYWAIT),
        .HIT          (HIT),
        .MEM_READ     (MEM_READ),
        .MEM_WRITE    (MEM_WRITE),
        .MEM_ADDRESS  (MEM_ADDRESS),
        .MEM_WRITEDATA(MEM_WRITEDATA),
        .MEM_READDATA (MEM_READDATA),
        .MEM_BUSYWAIT (MEM_BUSYWAIT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Block memory model: busy for LAT cycles of a request, then ready for one
    logic [127:0] mem_blk [16];
    int unsigned  mem_cnt;

    assign MEM_BUSYWAIT = (MEM_READ | MEM_WRITE) && (mem_cnt < LAT);
    assign MEM_READDATA = mem_blk[MEM_ADDRESS[3:0]];

    always @(posedge CLK) begin
        if (MEM_READ | MEM_WRITE) begin
            mem_cnt <= (mem_cnt == LAT) ? 0 : mem_cnt + 1;
            if (MEM_WRITE && !MEM_BUSYWAIT) mem_blk[MEM_ADDRESS[3:0]] <= MEM_WRITEDATA;
        end else begin
            mem_cnt <= 0;
        end
    end

    int n_checks;
    int n_fail;

    task automatic check_eq(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Per-request observations of the memory side
    int           stall;
    logic         hit_seen;
    logic [31:0]  rdata_seen;
    logic         rd_seen;
    logic [27:0]  rd_addr;
    logic         wr_seen;
    logic [27:0]  wr_addr;
    logic [127:0] wr_data;
    int           both_high;

    // Issue one CPU request, count stall cycles, sample everything at negedge+1
    task automatic do_req(input logic rd, input logic wr, input logic [31:0] addr,
                          input logic [31:0] wdata);
        logic done;
        done     = 1'b0;
        stall    = 0;
        rd_seen  = 1'b0;
        wr_seen  = 1'b0;
        rd_addr  = '0;
        wr_addr  = '0;
        wr_data  = '0;
        @(negedge CLK);
        MEMREAD   = rd;
        MEMWRITE  = wr;
        ADDRESS   = addr;
        WRITEDATA = wdata;
        for (int c = 0; c < 100; c++) begin
            #1;
            if (MEM_READ && MEM_WRITE) both_high++;
            if (MEM_READ && !rd_seen) begin
                rd_seen = 1'b1;
                rd_addr = MEM_ADDRESS;
            end
            if (MEM_WRITE && !wr_seen) begin
                wr_seen = 1'b1;
                wr_addr = MEM_ADDRESS;
                wr_data = MEM_WRITEDATA;
            end
            if (!BUSYWAIT) begin
                done = 1'b1;
                break;
            end
            stall++;
            @(negedge CLK);
        end
        check_eq("req_completes", 128'(done), 128'(1));
        hit_seen   = HIT;
        rdata_seen = READDATA;
        @(posedge CLK);
        #1;
        MEMREAD  = 1'b0;
        MEMWRITE = 1'b0;
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        both_high = 0;
        mem_cnt   = 0;
        for (int i = 0; i < 16; i++) begin
            mem_blk[i] = {32'(i * 256 + 3), 32'(i * 256 + 2), 32'(i * 256 + 1), 32'(i * 256)};
        end
        mem_blk[1] = {32'h4, 32'h3, 32'h2, 32'h1};
        RESET     = 1'b0;
        MEMREAD   = 1'b0;
        MEMWRITE  = 1'b0;
        ADDRESS   = 32'h0;
        WRITEDATA = 32'h0;
        repeat (2) @(negedge CLK);
        #1;
        check_eq("rst_busywait", 128'(BUSYWAIT), 128'(0));
        check_eq("rst_hit", 128'(HIT), 128'(0));
        check_eq("rst_mem_read", 128'(MEM_READ), 128'(0));
        check_eq("rst_mem_write", 128'(MEM_WRITE), 128'(0));
        check_eq("rst_mem_address", 128'(MEM_ADDRESS), 128'(0));
        check_eq("rst_mem_writedata", MEM_WRITEDATA, 128'(0));
        check_eq("rst_readdata", 128'(READDATA), 128'(0));
        @(negedge CLK);
        RESET = 1'b1;

        // Clean miss on index 1
        do_req(1'b1, 1'b0, 32'h0000_0010, 32'h0);
        check_eq("t1_stall", 128'(stall), 128'(LAT + 3));
        check_eq("t1_mem_read_addr", {rd_seen, rd_addr}, {1'b1, 28'h1});
        check_eq("t1_no_writeback", 128'(wr_seen), 128'(0));
        check_eq("t1_hit", 128'(hit_seen), 128'(1));
        check_eq("t1_rdata", 128'(rdata_seen), 128'(32'h1));

        // Write hit, then read it back
        do_req(1'b0, 1'b1, 32'h0000_0014, 32'hDEAD_BEEF);
        check_eq("t2_wr_stall", 128'(stall), 128'(0));
        check_eq("t2_wr_hit", 128'(hit_seen), 128'(1));
        do_req(1'b1, 1'b0, 32'h0000_0014, 32'h0);
        check_eq("t2_rd_stall", 128'(stall), 128'(0));
        check_eq("t2_rdata", 128'(rdata_seen), 128'(32'hDEAD_BEEF));

        // Dirty conflict miss on index 1
        do_req(1'b1, 1'b0, 32'h0000_0090, 32'h0);
        check_eq("t3_stall", 128'(stall), 128'(2 * LAT + 4));
        check_eq("t3_wb_addr", {wr_seen, wr_addr}, {1'b1, 28'h1});
        check_eq("t3_wb_data", wr_data, {32'h4, 32'h3, 32'hDEAD_BEEF, 32'h1});
        check_eq("t3_rd_addr", {rd_seen, rd_addr}, {1'b1, 28'h9});
        check_eq("t3_rdata", 128'(rdata_seen), 128'(32'h900));

        // Write miss on clean index 2
        do_req(1'b0, 1'b1, 32'h0000_0028, 32'h55);
        check_eq("t4_stall", 128'(stall), 128'(LAT + 3));
        check_eq("t4_rd_addr", {rd_seen, rd_addr}, {1'b1, 28'h2});
        check_eq("t4_no_writeback", 128'(wr_seen), 128'(0));
        do_req(1'b1, 1'b0, 32'h0000_0028, 32'h0);
        check_eq("t4_rdata", 128'(rdata_seen), 128'(32'h55));
        // Evicting index 2 proves the dirty bit was set
        do_req(1'b1, 1'b0, 32'h0000_00A8, 32'h0);
        check_eq("t4_evict_stall", 128'(stall), 128'(2 * LAT + 4));
        check_eq("t4_evict_data", {wr_seen, wr_addr, wr_data},
                 {1'b1, 28'h2, 32'h203, 32'h55, 32'h201, 32'h200});
        check_eq("t4_evict_rdata", 128'(rdata_seen), 128'(32'hA02));

        // Reset during ALLOCATE
        @(negedge CLK);
        MEMREAD = 1'b1;
        ADDRESS = 32'h0000_0030;
        @(negedge CLK);
        #1;
        check_eq("t5_in_allocate", {MEM_READ, MEM_ADDRESS}, {1'b1, 28'h3});
        RESET = 1'b0;
        #1;
        check_eq("t5_mem_read_drop", 128'(MEM_READ), 128'(0));
        check_eq("t5_busywait_drop", 128'(BUSYWAIT), 128'(0));
        @(negedge CLK);
        RESET   = 1'b1;
        MEMREAD = 1'b0;
        do_req(1'b1, 1'b0, 32'h0000_0090, 32'h0);
        check_eq("t5_reread_misses", 128'(stall), 128'(LAT + 3));
        check_eq("t5_reread_rdata", 128'(rdata_seen), 128'(32'h900));

        // Read and write together on a hit: write wins
        do_req(1'b1, 1'b1, 32'h0000_0094, 32'h77);
        check_eq("t6_stall", 128'(stall), 128'(0));
        check_eq("t6_hit", 128'(hit_seen), 128'(1));
        do_req(1'b1, 1'b0, 32'h0000_0094, 32'h0);
        check_eq("t6_rdata", 128'(rdata_seen), 128'(32'h77));

        check_eq("mem_rd_wr_exclusive", 128'(both_high), 128'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
